exc_flush_ctrl: RTL and testbench

Sequences the pipeline response to an exception or ERET committed in the write-back stage. It issues a same-cycle flush to all stages and computes the redirect target: the exception entry, or EPC for ERET. It then tracks and discards the in-flight instruction-fetch responses that belong to cancelled requests. Only after that does it hand the new PC to the fetch stage through a valid/ready redirect handshake. It sits between the WB stage (with its CP0 file) and the pre-IF/IF stage driving the SRAM-like instruction port.

---
 rtl/exc_flush_ctrl.sv | 117 +++++++++++
 tb/tb_exc_flush_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET flush sequencer: flushes the pipeline, drains cancelled
// instruction-fetch responses, then hands the redirect PC to fetch.
module exc_flush_ctrl #(
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380,
    parameter int          CNT_W    = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ws_ex,
    input  logic             ws_eret,
    input  logic [31:0]      cp0_epc,
    input  logic             inst_req,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic             fs_redirect_ready,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             fs_discard,
    output logic             inst_req_block,
    output logic             busy,
    output logic [CNT_W-1:0] outstanding
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ev;
    logic             inc;
    logic             dec;
    logic [31:0]      target;

    assign ev     = ws_ex | ws_eret;
    assign flush  = ev;
    assign target = ws_ex ? EX_ENTRY : cp0_epc;
    assign inc    = inst_req & inst_addr_ok;
    assign dec    = inst_data_ok & (outstanding != '0);
    assign busy   = (state != IDLE);

    // A response arriving alongside the event belongs to a request issued
    // before the flush, so it is dropped here and excluded from cnt_next.
    assign fs_discard = inst_data_ok & (ev | (state == DRAIN));

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = outstanding;
        if (inc && !dec) begin
            if (outstanding != CNT_MAX) cnt_next = outstanding + CNT_ONE;
        end else if (dec && !inc) begin
            cnt_next = outstanding - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) outstanding <= '0;
        else         outstanding <= cnt_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cancel_cnt     <= '0;
            redirect_pc    <= 32'h0;
            redirect_valid <= 1'b0;
            inst_req_block <= 1'b0;
        end else if (ev) begin
            // A new event restarts the sequence from any state.
            redirect_pc    <= target;
            cancel_cnt     <= cnt_next;
            inst_req_block <= 1'b1;
            if (cnt_next != '0) begin
                state          <= DRAIN;
                redirect_valid <= 1'b0;
            end else begin
                state          <= REDIRECT;
                redirect_valid <= 1'b1;
            end
        end else begin
            case (state)
                DRAIN: begin
                    if (inst_data_ok) begin
                        cancel_cnt <= cancel_cnt - CNT_ONE;
                        if (cancel_cnt == CNT_ONE) begin
                            state          <= REDIRECT;
                            redirect_valid <= 1'b1;
                        end
                    end
                end
                REDIRECT: begin
                    if (fs_redirect_ready) begin
                        state          <= IDLE;
                        redirect_valid <= 1'b0;
                        inst_req_block <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_cnt_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(inc && !dec && outstanding == CNT_MAX));

    a_no_accept_while_blocked: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_req_block && inst_addr_ok));

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed self-checking bench for exc_flush_ctrl; inputs change and outputs
// are sampled on the falling edge, state advances on the rising edge.
module tb_exc_flush_ctrl;

    localparam logic [31:0] EX_ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_ex, ws_eret;
    logic [31:0] cp0_epc;
    logic        inst_req, inst_addr_ok, inst_data_ok, fs_redirect_ready;
    logic        flush, redirect_valid, fs_discard, inst_req_block, busy;
    logic [31:0] redirect_pc;
    logic [1:0]  outstanding;

    int n_checks = 0;
    int n_errors = 0;

    exc_flush_ctrl #(.EX_ENTRY(EX_ENTRY), .CNT_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_ex             (ws_ex),
        .ws_eret           (ws_eret),
        .cp0_epc           (cp0_epc),
        .inst_req          (inst_req),
        .inst_addr_ok      (inst_addr_ok),
        .inst_data_ok      (inst_data_ok),
        .fs_redirect_ready (fs_redirect_ready),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fs_discard        (fs_discard),
        .inst_req_block    (inst_req_block),
        .busy              (busy),
        .outstanding       (outstanding)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge (inputs then settle for 1 time unit).
    task automatic next();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ws_ex = 0; ws_eret = 0; inst_req = 0; inst_addr_ok = 0;
        inst_data_ok = 0; fs_redirect_ready = 0;
    endtask

    // Two accepted fetches, leaving outstanding == 2 after the second edge.
    task automatic issue_two();
        next(); idle_inputs(); inst_req = 1; inst_addr_ok = 1;
        next();
        next(); idle_inputs(); #1;
        check("outstanding_two", 32'(outstanding), 32'd2);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_block"}, 32'(inst_req_block), 32'd0);
        check({tag, "_rv"},    32'(redirect_valid), 32'd0);
    endtask

    initial begin
        resetn = 0; cp0_epc = 32'h0; idle_inputs();
        #12;
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_pc",    redirect_pc, 32'h0);
        check("rst_out",   32'(outstanding), 32'd0);
        check_idle("rst");
        next(); resetn = 1;

        // No underflow: data_ok with nothing outstanding, not discarded in IDLE.
        next(); idle_inputs(); inst_data_ok = 1; #1;
        check("uflow_discard", 32'(fs_discard), 32'd0);
        next(); idle_inputs(); #1;
        check("uflow_out", 32'(outstanding), 32'd0);

        // Reset asserted mid-DRAIN clears everything immediately.
        issue_two();
        next(); ws_ex = 1; #1;
        check("t1_flush", 32'(flush), 32'd1);
        next(); idle_inputs(); #1;
        check("t1_drain_busy",  32'(busy), 32'd1);
        check("t1_drain_block", 32'(inst_req_block), 32'd1);
        check("t1_drain_rv",    32'(redirect_valid), 32'd0);
        #1 resetn = 0; #1;
        check("t1_rst_out", 32'(outstanding), 32'd0);
        check("t1_rst_pc",  redirect_pc, 32'h0);
        check_idle("t1_rst");
        next(); resetn = 1;

        // ws_ex with nothing outstanding: redirect next cycle, held while not ready.
        next(); idle_inputs(); ws_ex = 1; #1;
        check("t2_flush", 32'(flush), 32'd1);
        check("t2_rv0",   32'(redirect_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next(); idle_inputs(); #1;
            check("t2_hold_rv",    32'(redirect_valid), 32'd1);
            check("t2_hold_pc",    redirect_pc, EX_ENTRY);
            check("t2_hold_block", 32'(inst_req_block), 32'd1);
            check("t2_hold_flush", 32'(flush), 32'd0);
        end
        next(); fs_redirect_ready = 1; #1;
        check("t2_ready_rv", 32'(redirect_valid), 32'd1);
        next(); idle_inputs(); #1;
        check_idle("t2_done");

        // ERET with two outstanding: drain two non-adjacent responses first.
        cp0_epc = 32'h8000_1234;
        issue_two();
        next(); ws_eret = 1; #1;
        check("t3_flush", 32'(flush), 32'd1);
        next(); idle_inputs(); #1;
        check("t3_rv_a",      32'(redirect_valid), 32'd0);
        check("t3_nodiscard", 32'(fs_discard), 32'd0);
        next(); inst_data_ok = 1; #1;
        check("t3_discard1", 32'(fs_discard), 32'd1);
        next(); idle_inputs(); #1;
        check("t3_rv_b",  32'(redirect_valid), 32'd0);
        check("t3_busy",  32'(busy), 32'd1);
        check("t3_out1",  32'(outstanding), 32'd1);
        next(); inst_data_ok = 1; #1;
        check("t3_discard2", 32'(fs_discard), 32'd1);
        next(); idle_inputs(); #1;
        check("t3_rv",  32'(redirect_valid), 32'd1);
        check("t3_pc",  redirect_pc, 32'h8000_1234);
        check("t3_out", 32'(outstanding), 32'd0);
        check("t3_rdy_discard", 32'(fs_discard), 32'd0);
        fs_redirect_ready = 1;
        next(); idle_inputs(); #1;
        check_idle("t3_done");

        // Exception wins over ERET.
        cp0_epc = 32'h0000_1234;
        next(); ws_ex = 1; ws_eret = 1; #1;
        check("t4_flush", 32'(flush), 32'd1);
        next(); idle_inputs(); #1;
        check("t4_rv", 32'(redirect_valid), 32'd1);
        check("t4_pc", redirect_pc, EX_ENTRY);
        fs_redirect_ready = 1;
        next(); idle_inputs(); #1;
        check_idle("t4_done");

        // Event with simultaneous data_ok and accepted request, outstanding 1.
        cp0_epc = 32'h8000_1234;
        next(); inst_req = 1; inst_addr_ok = 1;
        next(); idle_inputs(); #1;
        check("t5_out1", 32'(outstanding), 32'd1);
        ws_ex = 1; inst_data_ok = 1; inst_req = 1; inst_addr_ok = 1; #1;
        check("t5_discard_ev", 32'(fs_discard), 32'd1);
        check("t5_flush",      32'(flush), 32'd1);
        next(); idle_inputs(); #1;
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_rv0",  32'(redirect_valid), 32'd0);
        check("t5_out",  32'(outstanding), 32'd1);
        next(); inst_data_ok = 1; #1;
        check("t5_discard", 32'(fs_discard), 32'd1);
        next(); idle_inputs(); #1;
        check("t5_rv", 32'(redirect_valid), 32'd1);
        check("t5_pc", redirect_pc, EX_ENTRY);
        fs_redirect_ready = 1;
        next(); idle_inputs(); #1;
        check_idle("t5_done");

        // Exception arriving during an ERET redirect replaces the target.
        cp0_epc = 32'h8000_5678;
        next(); ws_eret = 1;
        next(); idle_inputs(); #1;
        check("t6_pc_epc", redirect_pc, 32'h8000_5678);
        check("t6_rv_epc", 32'(redirect_valid), 32'd1);
        ws_ex = 1; #1;
        check("t6_flush", 32'(flush), 32'd1);
        next(); idle_inputs(); fs_redirect_ready = 1; #1;
        check("t6_pc_ex", redirect_pc, EX_ENTRY);
        check("t6_rv_ex", 32'(redirect_valid), 32'd1);
        next(); idle_inputs(); #1;
        check_idle("t6_done");
        check("t6_pc_kept", redirect_pc, EX_ENTRY);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
